demux116_deser: RTL and testbench
=================================

DEMUX116_DESER -- requirements
Module: demux116_deser

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 16 and index width at 4.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clr  input  1  synchronous word abort; discards a partial word.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_ready  output  1  block accepts a bit this cycle.
REQ-008 dout  output  16  assembled parallel word.
REQ-009 dout_valid  output  1  dout holds a complete word.
REQ-010 dout_ready  input  1  consumer takes dout this cycle.
REQ-011 idx  output  4  bit position the next accepted bit is written to.

Function
REQ-012 The block SHALL have two states: FILL (collecting bits) and FULL (word held for the consumer).
REQ-013 In FILL, din_ready SHALL be 1; in FULL, din_ready SHALL be 0.
REQ-014 A bit SHALL be accepted on a rising edge when din_valid=1 and din_ready=1; it SHALL be written to dout[idx] and idx SHALL advance by one.
REQ-015 Bits not accepted, and dout bits not yet written in the current word, SHALL leave the other dout bits unchanged.
REQ-016 When the bit accepted is the 16th of the word, the state SHALL go FILL->FULL on that edge; dout_valid SHALL be 1 from the next cycle (latency 1 cycle from the last bit).
REQ-017 In FULL, dout and dout_valid SHALL hold stable until a cycle with dout_ready=1; on that edge the state SHALL go FULL->FILL, dout_valid SHALL drop, and idx SHALL return to its start value.
REQ-018 dout_valid SHALL be 1 exactly when the state is FULL.
REQ-019 If din_valid and dout_ready are both 1 in FULL, the word SHALL be released, and the input bit SHALL NOT be accepted (din_ready=0 that cycle).
REQ-020 After the FULL->FILL transition, the first bit of the next word SHALL be accepted on the following cycle; sustained throughput is 16 bits per 17 cycles.
REQ-021 clr=1 SHALL return idx to its start value and the state to FILL on the next edge, and SHALL drop dout_valid, in either state. clr SHALL take priority over bit acceptance and over dout_ready. dout contents after clr SHALL be don't-care.
REQ-022 idx SHALL wrap modulo 16 with no extra bubble; wrapping only happens together with the FILL->FULL transition.

Reset
REQ-023 While rst=1, the following SHALL hold asynchronously and independent of clk: state=FILL, dout=16'h0000, dout_valid=0, and idx at its start value.
REQ-024 Reset released mid-word SHALL leave no trace of the aborted word; the first bit accepted after reset SHALL go to the start position.

Configuration
REQ-025 The macro DEMUX_MSB_FIRST_EN SHALL select the bit order at compile time.
REQ-026 Without DEMUX_MSB_FIRST_EN, the order SHALL be LSB first: idx start value 0, incrementing 0->15, first bit lands in dout[0].
REQ-027 With DEMUX_MSB_FIRST_EN, the order SHALL be MSB first: idx start value 15, decrementing 15->0, first bit lands in dout[15].
REQ-028 All handshake timing SHALL be identical in both builds.

Verification
REQ-029 LSB build: reset, then 16 back-to-back accepted bits of pattern 0xA5C3 (LSB first), dout_ready=0 -> dout_valid=1 one cycle after the 16th bit, dout=16'hA5C3, din_ready=0, idx=0.
REQ-030 Backpressure: hold dout_ready=0 for 5 cycles with din_valid=1 -> dout stays 0xA5C3, no bit accepted; dout_ready=1 for one cycle -> dout_valid=0, din_ready=1 next cycle.
REQ-031 Gaps: 16 bits of 0xFFFF with din_valid toggling every other cycle -> word completes after 31 cycles, dout=16'hFFFF, idx advances only on valid cycles.
REQ-032 Abort: 7 bits accepted, then clr=1 together with din_valid=1 -> idx=0, bit ignored; next 16 bits 0x1234 -> dout=16'h1234.
REQ-033 Async reset: assert rst mid-FULL between clock edges -> dout_valid=0, dout=0, idx=0 immediately, without waiting for a clock edge.
REQ-034 MSB build: shift 0x8001 MSB first -> first bit lands in dout[15], idx counts 15->0, final dout=16'h8001.

Source files
------------

// File: rtl/demux116_deser.sv
// -----------------------------------------------------------------------------
// demux116_deser -- 1-to-16 serial-to-parallel deserializer with handshakes.
//
// Collects 16 serial bits into a parallel word (FILL state), then holds the
// word for the consumer (FULL state) until it is taken.
//
// Build option:
//   DEMUX_MSB_FIRST_EN  defined   -> MSB first (idx starts at 15, counts down)
//                       undefined -> LSB first (idx starts at 0, counts up)
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous active-high reset
//   clr         in   1   synchronous word abort (discards a partial word)
//   din         in   1   serial data bit
//   din_valid   in   1   din is valid this cycle
//   din_ready   out  1   block accepts a bit this cycle (state FILL)
//   dout        out  16  assembled parallel word
//   dout_valid  out  1   dout holds a complete word (state FULL)
//   dout_ready  in   1   consumer takes dout this cycle
//   idx         out  4   bit position the next accepted bit is written to
// -----------------------------------------------------------------------------
module demux116_deser (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [3:0]  idx
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

`ifdef DEMUX_MSB_FIRST_EN
  localparam logic [3:0] IDX_START = 4'd15;
  localparam logic [3:0] IDX_LAST  = 4'd0;

  function automatic logic [3:0] idx_advance(input logic [3:0] i_idx);
    return i_idx - 4'd1;
  endfunction
`else
  localparam logic [3:0] IDX_START = 4'd0;
  localparam logic [3:0] IDX_LAST  = 4'd15;

  function automatic logic [3:0] idx_advance(input logic [3:0] i_idx);
    return i_idx + 4'd1;
  endfunction
`endif

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [15:0] r_dout;

  state_t      w_state_next;
  logic [3:0]  w_idx_next;
  logic [15:0] w_dout_next;

  // Next-state, next-index and next-word computation.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_dout_next  = r_dout;
    if (clr) begin
      // Abort wins over acceptance and release; dout bits are left as-is.
      w_state_next = S_FILL;
      w_idx_next   = IDX_START;
    end else begin
      case (r_state)
        S_FILL: begin
          if (din_valid) begin
            w_dout_next[r_idx] = din;
            // The natural modulo-16 wrap lands idx on IDX_START exactly
            // when the word completes.
            w_idx_next = idx_advance(r_idx);
            if (r_idx == IDX_LAST) begin
              w_state_next = S_FULL;
            end else begin
              w_state_next = S_FILL;
            end
          end else begin
            w_state_next = S_FILL;
          end
        end
        S_FULL: begin
          // din is ignored here: din_ready is low for the whole FULL state.
          if (dout_ready) begin
            w_state_next = S_FILL;
            w_idx_next   = IDX_START;
          end else begin
            w_state_next = S_FULL;
          end
        end
        default: begin
          w_state_next = S_FILL;
          w_idx_next   = IDX_START;
        end
      endcase
    end
  end

  // State, index and word registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_idx   <= IDX_START;
      r_dout  <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_dout  <= w_dout_next;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign din_ready  = (r_state == S_FILL);
  assign dout_valid = (r_state == S_FULL);
  assign dout       = r_dout;
  assign idx        = r_idx;

endmodule

// File: tb/tb_demux116_deser.sv
// -----------------------------------------------------------------------------
// tb_demux116_deser -- scoreboard bench for demux116_deser.
// A bit-counting reference model pushes each completed word into a queue;
// a negedge monitor compares DUT outputs against the model every cycle and
// pops the queue whenever the consumer takes a word.
// Honours DEMUX_MSB_FIRST_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_demux116_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [3:0]  idx;

  int checks = 0;
  int failures = 0;
  int released = 0;

  // Reference model state: bits accepted in the current word, word image,
  // mask of bits known to be written, and whether a word is being held.
  int          m_cnt;
  logic        m_full;
  logic [15:0] m_word;
  logic [15:0] m_mask;
  logic [15:0] sb_q[$];

  demux116_deser dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .idx        (idx)
  );

  always #5 clk = ~clk;

  // Bit position of the k-th bit of a word in the selected order.
  function automatic int pos(input int k);
`ifdef DEMUX_MSB_FIRST_EN
    return 15 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [15:0] set_bit(input logic [15:0] w, input int p, input logic b);
    logic [15:0] r;
    r = w;
    r[p] = b;
    return r;
  endfunction

  function automatic logic [3:0] start_idx();
    return 4'(pos(0));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model, advanced on the same clock edge as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_word <= 16'h0000;
      m_mask <= 16'hFFFF;
      sb_q.delete();
    end else if (clr) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_mask <= 16'h0000;
      if (m_full && sb_q.size() > 0) sb_q.delete(0);
    end else if (!m_full) begin
      if (din_valid) begin
        m_word <= set_bit(m_word, pos(m_cnt), din);
        m_mask <= set_bit(m_mask, pos(m_cnt), 1'b1);
        if (m_cnt == 15) begin
          m_cnt  <= 0;
          m_full <= 1'b1;
          sb_q.push_back(set_bit(m_word, pos(m_cnt), din));
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (dout_ready) begin
      m_full <= 1'b0;
    end
  end

  // Monitor: compare outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("dout_valid", 32'(dout_valid), 32'(m_full));
      chk("din_ready", 32'(din_ready), 32'(!m_full));
      chk("idx", 32'(idx), 32'(pos(m_cnt)));
      chk("dout_written_bits", 32'(dout & m_mask), 32'(m_word & m_mask));
      if (dout_valid && dout_ready && !clr) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          chk("released_word", 32'(dout), 32'(sb_q.pop_front()));
          released++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and hold it until it is accepted (bounded wait).
  task automatic put_bit(input logic b);
    int n;
    n = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("put_bit_timeout", 32'd1, 32'd0);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 16; k++) put_bit(w[pos(k)]);
  endtask

  task automatic release_word();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held.
    tick();
    tick();
    chk("reset_dout", 32'(dout), 32'h0000);
    chk("reset_dout_valid", 32'(dout_valid), 32'd0);
    chk("reset_idx", 32'(idx), 32'(start_idx()));
    chk("reset_din_ready", 32'(din_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Back-to-back word, consumer not ready.
    send_word(16'hA5C3);
    chk("word_a5c3_valid", 32'(dout_valid), 32'd1);
    chk("word_a5c3_dout", 32'(dout), 32'hA5C3);
    chk("word_a5c3_din_ready", 32'(din_ready), 32'd0);
    chk("word_a5c3_idx", 32'(idx), 32'(start_idx()));

    // Backpressure with input offered: nothing accepted, word held.
    din = 1'b0;
    din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_dout", 32'(dout), 32'hA5C3);
      chk("hold_valid", 32'(dout_valid), 32'd1);
    end
    din_valid = 1'b0;
    release_word();
    chk("release_valid_low", 32'(dout_valid), 32'd0);
    chk("release_din_ready", 32'(din_ready), 32'd1);

    // Alternate-cycle valid: 16 bits complete after 31 edges.
    din = 1'b1;
    for (int c = 0; c < 31; c++) begin
      din_valid = (c % 2 == 0);
      tick();
      if (c == 29) chk("gap_not_yet_valid", 32'(dout_valid), 32'd0);
    end
    din_valid = 1'b0;
    chk("gap_valid", 32'(dout_valid), 32'd1);
    chk("gap_dout", 32'(dout), 32'hFFFF);
    release_word();

    // Abort mid-word with a simultaneous valid bit.
    for (int k = 0; k < 7; k++) put_bit(1'($urandom_range(0, 1)));
    chk("pre_abort_idx", 32'(idx), 32'(pos(7)));
    clr = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    tick();
    clr = 1'b0;
    din_valid = 1'b0;
    chk("abort_idx", 32'(idx), 32'(start_idx()));
    send_word(16'h1234);
    chk("after_abort_dout", 32'(dout), 32'h1234);
    release_word();

    // Asynchronous reset asserted between edges while FULL.
    send_word(16'h8001);
    chk("msb_pattern_dout", 32'(dout), 32'h8001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(dout_valid), 32'd0);
    chk("async_rst_dout", 32'(dout), 32'h0000);
    chk("async_rst_idx", 32'(idx), 32'(start_idx()));
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic; the monitor does the checking.
    for (int c = 0; c < 3000; c++) begin
      din        = 1'($urandom_range(0, 1));
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) == 0);
      clr        = ($urandom_range(0, 63) == 0);
      tick();
    end
    clr = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    dout_ready = 1'b0;
    tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    checks++;
    if (released < 50) begin
      failures++;
      $display("FAIL released_count actual=%0d expected>=50", released);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
